// File: rtl/wb_slot_arbiter.sv
// rtl/wb_slot_arbiter.sv - time-division Wishbone arbiter with fixed slot frame map
// Optional build macro WB_ARB_RECLAIM_EN hands an unused slot to the next requesting controller.
module wb_slot_arbiter #(
    parameter int NUM_CTL        = 3,
    parameter int IDX_W          = $clog2(NUM_CTL),
    parameter int SLOT_CYCLES    = 16,
    parameter int FRAME_SLOTS    = 4,
    parameter logic [FRAME_SLOTS*IDX_W-1:0] SLOT_MAP = {2'd1, 2'd2, 2'd1, 2'd0},
    parameter int TIMEOUT_CYCLES = 32,
    parameter int WB_ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                             wb_clock_i,
    input  logic                             wb_reset_ni,
    input  logic [NUM_CTL*WB_ADDR_WIDTH-1:0] ctl_addr_i,
    input  logic [NUM_CTL*DATA_WIDTH-1:0]    ctl_data_i,
    input  logic [NUM_CTL-1:0]               ctl_we_i,
    input  logic [NUM_CTL-1:0]               ctl_cycle_i,
    input  logic [NUM_CTL-1:0]               ctl_strobe_i,
    output logic [NUM_CTL-1:0]               ctl_stall_o,
    output logic [NUM_CTL-1:0]               ctl_ack_o,
    output logic [NUM_CTL-1:0]               ctl_err_o,
    output logic [DATA_WIDTH-1:0]            ctl_data_o,
    output logic [NUM_CTL-1:0]               grant_o,
    output logic                             grant_strobe_o,
    output logic [WB_ADDR_WIDTH-1:0]         wb_addr_o,
    output logic [DATA_WIDTH-1:0]            wb_data_o,
    output logic                             wb_we_o,
    output logic                             wb_cycle_o,
    output logic                             wb_strobe_o,
    input  logic [DATA_WIDTH-1:0]            wb_data_i,
    input  logic                             wb_stall_i,
    input  logic                             wb_ack_i
);

    localparam int CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SIDX_W = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(FRAME_SLOTS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [CNT_W-1:0]  cnt;
    logic [SIDX_W-1:0] sidx;
    logic [SIDX_W-1:0] sidx_next;
    logic [1:0]        state;
    logic              running;
    logic [IDX_W-1:0]  slot_owner;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  active;
    logic [IDX_W-1:0]  sel;
    logic [TMR_W-1:0]  tmr;

    logic [NUM_CTL-1:0] req;
    logic slot_start;
    logic in_xfer;
    logic ack_hit;
    logic tmo_hit;
    logic done;
    logic freeze;
    logic wrap;
    logic accept;
    logic bus_on;

    logic [WB_ADDR_WIDTH-1:0] addr_arr [NUM_CTL];
    logic [DATA_WIDTH-1:0]    data_arr [NUM_CTL];
    logic [IDX_W-1:0]         map_arr  [FRAME_SLOTS];

    for (genvar g = 0; g < NUM_CTL; g++) begin : g_unpack_ctl
        assign addr_arr[g] = ctl_addr_i[g*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        assign data_arr[g] = ctl_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar g = 0; g < FRAME_SLOTS; g++) begin : g_unpack_map
        assign map_arr[g] = SLOT_MAP[g*IDX_W +: IDX_W];
    end

    assign req        = ctl_cycle_i & ctl_strobe_i;
    assign slot_start = running && (cnt == '0);
    assign in_xfer    = (state != ST_IDLE);
    assign ack_hit    = in_xfer && wb_ack_i;
    assign tmo_hit    = in_xfer && !wb_ack_i && (tmr == TMR_LAST);
    assign done       = ack_hit || tmo_hit;
    // The last cycle of a slot stretches while a transfer is still outstanding.
    assign freeze     = in_xfer && (cnt == CNT_LAST) && !done;
    assign wrap       = (cnt == CNT_LAST) && !freeze;
    assign sidx_next  = (sidx == SIDX_LAST) ? '0 : sidx + SIDX_W'(1);

`ifdef WB_ARB_RECLAIM_EN
    logic found;
    int   cand;

    always_comb begin
        owner = slot_owner;
        found = 1'b0;
        cand  = 0;
        if (slot_start && (state == ST_IDLE) && !req[slot_owner]) begin
            for (int k = 1; k < NUM_CTL; k++) begin
                cand = int'(slot_owner) + k;
                if (cand >= NUM_CTL) begin
                    cand = cand - NUM_CTL;
                end
                if (!found && req[IDX_W'(cand)]) begin
                    owner = IDX_W'(cand);
                    found = 1'b1;
                end
            end
        end
    end
`else
    assign owner = slot_owner;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CTL; i++) begin
            grant_o[i] = running && (owner == IDX_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CTL; i++) begin
            ctl_stall_o[i] = running &&
                (!(grant_o[i] && slot_start && (state == ST_IDLE)) || wb_stall_i);
        end
    end

    assign accept = slot_start && (state == ST_IDLE) && req[owner] && !wb_stall_i;
    assign sel    = accept ? owner : active;
    assign bus_on = accept || in_xfer;

    always_comb begin
        wb_cycle_o  = bus_on;
        wb_strobe_o = accept;
        wb_addr_o   = '0;
        wb_data_o   = '0;
        wb_we_o     = 1'b0;
        if (bus_on) begin
            wb_addr_o = addr_arr[sel];
            wb_data_o = data_arr[sel];
            wb_we_o   = ctl_we_i[sel];
        end
    end

    // Reset parks the counters on the last cycle so the first clock opens slot 0.
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            cnt            <= CNT_LAST;
            sidx           <= SIDX_LAST;
            state          <= ST_IDLE;
            running        <= 1'b0;
            slot_owner     <= '0;
            active         <= '0;
            tmr            <= '0;
            grant_strobe_o <= 1'b0;
            ctl_ack_o      <= '0;
            ctl_err_o      <= '0;
            ctl_data_o     <= '0;
        end else begin
            grant_strobe_o <= wrap;
            ctl_ack_o      <= '0;
            ctl_err_o      <= '0;

            if (!freeze) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end

            if (wrap) begin
                sidx       <= sidx_next;
                slot_owner <= map_arr[sidx_next];
                running    <= 1'b1;
            end else if (slot_start) begin
                slot_owner <= owner;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_BUSY;
                        active <= owner;
                        tmr    <= TMR_W'(1);
                    end
                end
                ST_BUSY, ST_HOLD: begin
                    tmr <= tmr + TMR_W'(1);
                    if (ack_hit) begin
                        ctl_ack_o[active] <= 1'b1;
                        ctl_data_o        <= wb_data_i;
                        state             <= ST_IDLE;
                    end else if (tmo_hit) begin
                        ctl_err_o[active] <= 1'b1;
                        state             <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HOLD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
